// File: rtl/keypad_scan_fsm_pkg.sv
// -----------------------------------------------------------------------------
// keypad_scan_fsm_pkg
// Shared definitions for the 4x4 keypad scanner:
//   - kp_state_e : one-hot scanner state encoding (SCAN, DEBOUNCE, PRESSED, RELEASE)
//   - COL_RESET  : column drive pattern after reset
//   - lowest_set_idx / onehot_idx / rotl1 : small index/rotation helpers
// -----------------------------------------------------------------------------
package keypad_scan_fsm_pkg;

    typedef enum logic [3:0] {
        SCAN     = 4'b0001,
        DEBOUNCE = 4'b0010,
        PRESSED  = 4'b0100,
        RELEASE  = 4'b1000
    } kp_state_e;

    localparam logic [3:0] COL_RESET = 4'b0001;

    // Index of the lowest set bit; with several rows pressed the lowest row wins.
    function automatic logic [1:0] lowest_set_idx(input logic [3:0] v);
        logic [1:0] idx;
        if (v[0]) begin
            idx = 2'd0;
        end else if (v[1]) begin
            idx = 2'd1;
        end else if (v[2]) begin
            idx = 2'd2;
        end else if (v[3]) begin
            idx = 2'd3;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    // Index of a one-hot column drive; anything else maps to column 0.
    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Rotate a 4-bit column pattern left by one (0001 -> 0010 -> ... -> 0001).
    function automatic logic [3:0] rotl1(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/keypad_scan_fsm_tick_gen.sv
// -----------------------------------------------------------------------------
// keypad_scan_fsm_tick_gen
// Free-running prescaler producing a registered one-clock scan_tick every
// SCAN_DIV clocks. The first tick arrives on the SCAN_DIV-th clock edge after
// reset is released.
// Ports:
//   clk          in  system clock
//   reset_p      in  asynchronous reset, active-high
//   scan_tick_o  out 1-clk strobe every SCAN_DIV clocks
// Parameters:
//   SCAN_DIV     clocks per tick, >= 2
// -----------------------------------------------------------------------------
module keypad_scan_fsm_tick_gen #(
    parameter logic [16:0] SCAN_DIV = 17'd100000
) (
    input  logic clk,
    input  logic reset_p,
    output logic scan_tick_o
);

    logic [16:0] div_cnt_q;
    logic [16:0] div_cnt_d;
    logic        tick_q;
    logic        tick_d;

    // Prescaler next-count and tick decode (tick registered one count early).
    always_comb begin
        div_cnt_d = div_cnt_q;
        tick_d    = 1'b0;
        if (div_cnt_q == (SCAN_DIV - 17'd1)) begin
            div_cnt_d = 17'd0;
        end else begin
            div_cnt_d = div_cnt_q + 17'd1;
        end
        if (div_cnt_q == (SCAN_DIV - 17'd2)) begin
            tick_d = 1'b1;
        end else begin
            tick_d = 1'b0;
        end
    end

    // Prescaler and tick registers.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            div_cnt_q <= 17'd0;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
        end
    end

    assign scan_tick_o = tick_q;

endmodule

// File: rtl/keypad_scan_fsm.sv
// -----------------------------------------------------------------------------
// keypad_scan_fsm
// 4x4 matrix keypad scanner with debounce. Drives one column at a time,
// samples the rows on each scan tick, debounces press and release, and
// presents a held key code with a level-valid flag.
// Ports:
//   clk        in  1  system clock
//   reset_p    in  1  asynchronous reset, active-high
//   row        in  4  row sense, active-high
//   col        out 4  column drive, one-hot, active-high
//   key_value  out 4  {row_idx, col_idx} of the last accepted key (held after release)
//   key_valid  out 1  high while a debounced key is held
// Build option:
//   KEYPAD_SCAN_AUTOREPEAT_EN : while a key is held, key_valid drops for one
//   clock every REPEAT_TICKS scan ticks so the consumer sees a fresh edge.
// -----------------------------------------------------------------------------
module keypad_scan_fsm
    import keypad_scan_fsm_pkg::*;
#(
    parameter logic [16:0] SCAN_DIV       = 17'd100000,
    parameter logic [3:0]  DEBOUNCE_TICKS = 4'd8,
    parameter logic [7:0]  REPEAT_TICKS   = 8'd50
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_value,
    output logic       key_valid
);

    kp_state_e  state_q;
    kp_state_e  state_d;
    logic [3:0] col_q;
    logic [3:0] col_d;
    logic [3:0] row_snap_q;
    logic [3:0] row_snap_d;
    logic [3:0] deb_cnt_q;
    logic [3:0] deb_cnt_d;
    logic [3:0] key_value_q;
    logic [3:0] key_value_d;
    logic       key_valid_q;
    logic       key_valid_d;
    logic       scan_tick_s;
    logic [4:0] deb_inc_s;
    logic       deb_done_s;
    logic       rpt_fire_s;

    keypad_scan_fsm_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk         (clk),
        .reset_p     (reset_p),
        .scan_tick_o (scan_tick_s)
    );

    // Incremented debounce count and "this tick completes the window" flag.
    always_comb begin
        deb_inc_s  = {1'b0, deb_cnt_q} + 5'd1;
        deb_done_s = (deb_inc_s >= ({1'b0, DEBOUNCE_TICKS} - 5'd1));
    end

    // Scanner next-state, column, snapshot and debounce counter.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_snap_d = row_snap_q;
        deb_cnt_d  = deb_cnt_q;
        if (scan_tick_s) begin
            case (state_q)
                SCAN: begin
                    if (row == 4'd0) begin
                        col_d = rotl1(col_q);
                    end else begin
                        // Column is held so the debounce samples the same key.
                        row_snap_d = row;
                        deb_cnt_d  = 4'd0;
                        state_d    = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (row == row_snap_q) begin
                        deb_cnt_d = deb_inc_s[3:0];
                        if (deb_done_s) begin
                            state_d = PRESSED;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        // Bounce: resample the same column on the next tick.
                        state_d = SCAN;
                    end
                end
                PRESSED: begin
                    if (row == 4'd0) begin
                        deb_cnt_d = 4'd0;
                        state_d   = RELEASE;
                    end else begin
                        state_d = PRESSED;
                    end
                end
                RELEASE: begin
                    if (row == 4'd0) begin
                        deb_cnt_d = deb_inc_s[3:0];
                        if (deb_done_s) begin
                            col_d   = rotl1(col_q);
                            state_d = SCAN;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        // Release glitch: key is still down.
                        deb_cnt_d = 4'd0;
                        state_d   = PRESSED;
                    end
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
    logic [7:0] rpt_cnt_q;
    logic [7:0] rpt_cnt_d;

    // Auto-repeat tick counter; only runs while the key is held in PRESSED.
    always_comb begin
        rpt_cnt_d  = rpt_cnt_q;
        rpt_fire_s = 1'b0;
        if (state_q != PRESSED) begin
            rpt_cnt_d = 8'd0;
        end else if (scan_tick_s && (row != 4'd0)) begin
            if (rpt_cnt_q >= (REPEAT_TICKS - 8'd1)) begin
                rpt_cnt_d  = 8'd0;
                rpt_fire_s = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 8'd1;
            end
        end else begin
            rpt_cnt_d = rpt_cnt_q;
        end
    end

    // Auto-repeat counter register.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            rpt_cnt_q <= 8'd0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    // No auto-repeat: the gap strobe is tied low. REPEAT_TICKS is still
    // referenced so the parameter list is identical in both builds.
    assign rpt_fire_s = 1'b0 & (REPEAT_TICKS != 8'd0);
`endif

    // Output next-values: valid follows the held states one clock later,
    // the code is captured while PRESSED and kept after release.
    always_comb begin
        key_valid_d = 1'b0;
        key_value_d = key_value_q;
        if (((state_q == PRESSED) || (state_q == RELEASE)) && !rpt_fire_s) begin
            key_valid_d = 1'b1;
        end else begin
            key_valid_d = 1'b0;
        end
        if (state_q == PRESSED) begin
            key_value_d = {lowest_set_idx(row_snap_q), onehot_idx(col_q)};
        end else begin
            key_value_d = key_value_q;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q     <= SCAN;
            col_q       <= COL_RESET;
            row_snap_q  <= 4'd0;
            deb_cnt_q   <= 4'd0;
            key_value_q <= 4'd0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_snap_q  <= row_snap_d;
            deb_cnt_q   <= deb_cnt_d;
            key_value_q <= key_value_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign col       = col_q;
    assign key_value = key_value_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scan_fsm.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_fsm
// Self-checking bench for keypad_scan_fsm with SCAN_DIV=4, DEBOUNCE_TICKS=3,
// REPEAT_TICKS=5. Expectations come from tick arithmetic: scan ticks land on
// every 4th clock after reset release, the column index advances once per idle
// tick, a press is accepted after 3 ticks and reported one clock later.
// -----------------------------------------------------------------------------
module tb_keypad_scan_fsm;

    localparam int DIV = 4;
    localparam int DT  = 3;
    localparam int RT  = 5;
`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       reset_p = 1'b1;
    logic [3:0] row     = 4'd0;
    logic [3:0] col;
    logic [3:0] key_value;
    logic       key_valid;

    int         n_checks  = 0;
    int         n_pass    = 0;
    int         phase     = 0;
    int         mcol      = 0;
    logic [3:0] last_code = 4'd0;

    keypad_scan_fsm #(
        .SCAN_DIV       (17'(DIV)),
        .DEBOUNCE_TICKS (4'(DT)),
        .REPEAT_TICKS   (8'(RT))
    ) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .row       (row),
        .col       (col),
        .key_value (key_value),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_col(input int c);
        return 4'(1 << c);
    endfunction

    // {row_idx, col_idx} with the lowest pressed row winning.
    function automatic logic [3:0] exp_code(input logic [3:0] r, input int c);
        int ri;
        ri = 0;
        for (int i = 3; i >= 0; i--) if (r[i]) ri = i;
        return 4'(ri * 4 + c);
    endfunction

    task automatic step_clk;
        @(posedge clk);
        #1;
        phase = (phase + 1) % DIV;
    endtask

    task automatic next_tick;
        do step_clk(); while (phase != 0);
    endtask

    task automatic idle_to_col(input int c);
        while (mcol != c) begin
            next_tick();
            mcol = (mcol + 1) % 4;
        end
    endtask

    // Full press / hold / optional release-glitch / release sequence.
    task automatic run_press(input int c, input logic [3:0] r, input int hold, input int glitch_at);
        logic [3:0] code;
        logic       exp_v;
        code = exp_code(r, c);
        idle_to_col(c);
        row = r;
        for (int k = 1; k <= DT; k++) begin
            next_tick();
            n_checks++;
            if ({key_valid, col} !== {1'b0, exp_col(c)})
                $display("FAIL debounce tick %0d: got valid,col=%b expected %b", k, {key_valid, col}, {1'b0, exp_col(c)});
            else n_pass++;
        end
        step_clk();
        n_checks++;
        if ({key_valid, key_value} !== {1'b1, code})
            $display("FAIL press-rise: got valid,value=%b expected %b", {key_valid, key_value}, {1'b1, code});
        else n_pass++;
        for (int j = 1; j <= hold; j++) begin
            next_tick();
            exp_v = (AUTOREP && (j % RT == 0)) ? 1'b0 : 1'b1;
            n_checks++;
            if ({key_valid, col, key_value} !== {exp_v, exp_col(c), code})
                $display("FAIL hold tick %0d: got valid,col,value=%b expected %b", j, {key_valid, col, key_value}, {exp_v, exp_col(c), code});
            else n_pass++;
        end
        if (glitch_at > 0) begin
            row = 4'd0;
            for (int g = 1; g <= glitch_at; g++) begin
                next_tick();
                n_checks++;
                if ({key_valid, col} !== {1'b1, exp_col(c)})
                    $display("FAIL pre-glitch tick %0d: got %b expected %b", g, {key_valid, col}, {1'b1, exp_col(c)});
                else n_pass++;
            end
            row = r;
            next_tick();
            n_checks++;
            if ({key_valid, col} !== {1'b1, exp_col(c)})
                $display("FAIL release-glitch: got valid,col=%b expected %b", {key_valid, col}, {1'b1, exp_col(c)});
            else n_pass++;
        end
        row = 4'd0;
        for (int k = 1; k <= DT; k++) begin
            next_tick();
            n_checks++;
            if ({key_valid, col} !== {1'b1, exp_col((k < DT) ? c : (c + 1) % 4)})
                $display("FAIL release tick %0d: got valid,col=%b expected %b", k, {key_valid, col}, {1'b1, exp_col((k < DT) ? c : (c + 1) % 4)});
            else n_pass++;
        end
        step_clk();
        n_checks++;
        if ({key_valid, key_value} !== {1'b0, code})
            $display("FAIL release-fall: got valid,value=%b expected %b", {key_valid, key_value}, {1'b0, code});
        else n_pass++;
        mcol      = (c + 1) % 4;
        last_code = code;
    endtask

    task automatic test_reset;
        reset_p = 1'b1;
        row     = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({key_valid, col, key_value} !== {1'b0, 4'b0001, 4'h0})
            $display("FAIL reset-state: got %b expected %b", {key_valid, col, key_value}, {1'b0, 4'b0001, 4'h0});
        else n_pass++;
        reset_p   = 1'b0;
        phase     = 0;
        mcol      = 0;
        last_code = 4'd0;
        step_clk();
        n_checks++;
        if ({key_valid, col} !== {1'b0, 4'b0001})
            $display("FAIL reset-hold: got %b expected %b", {key_valid, col}, {1'b0, 4'b0001});
        else n_pass++;
    endtask

    task automatic test_scan;
        for (int i = 0; i < 8; i++) begin
            next_tick();
            mcol = (mcol + 1) % 4;
            n_checks++;
            if ({key_valid, col} !== {1'b0, exp_col(mcol)})
                $display("FAIL scan-rotate %0d: got %b expected %b", i, {key_valid, col}, {1'b0, exp_col(mcol)});
            else n_pass++;
            step_clk();
            n_checks++;
            if (col !== exp_col(mcol))
                $display("FAIL scan-between %0d: got %b expected %b", i, col, exp_col(mcol));
            else n_pass++;
        end
    endtask

    task automatic test_press_basic;
        run_press(2, 4'b0010, 2, 0);
        n_checks++;
        if (last_code !== 4'h6 || key_value !== 4'h6)
            $display("FAIL press-code: got %h expected %h", key_value, 4'h6);
        else n_pass++;
    endtask

    task automatic test_bounce(input int c, input logic [3:0] r, input int len);
        idle_to_col(c);
        row = r;
        for (int k = 1; k <= len; k++) begin
            next_tick();
            n_checks++;
            if ({key_valid, col} !== {1'b0, exp_col(c)})
                $display("FAIL bounce-hold %0d: got %b expected %b", k, {key_valid, col}, {1'b0, exp_col(c)});
            else n_pass++;
        end
        row = 4'd0;
        next_tick();
        n_checks++;
        if ({key_valid, col, key_value} !== {1'b0, exp_col(c), last_code})
            $display("FAIL bounce-resample: got %b expected %b", {key_valid, col, key_value}, {1'b0, exp_col(c), last_code});
        else n_pass++;
        next_tick();
        n_checks++;
        if ({key_valid, col} !== {1'b0, exp_col((c + 1) % 4)})
            $display("FAIL bounce-resume: got %b expected %b", {key_valid, col}, {1'b0, exp_col((c + 1) % 4)});
        else n_pass++;
        mcol = (c + 1) % 4;
    endtask

    task automatic test_multirow_glitch;
        run_press(0, 4'b0110, 1, 1);
        n_checks++;
        if (key_value !== 4'h4)
            $display("FAIL multirow-code: got %h expected %h", key_value, 4'h4);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        idle_to_col(3);
        row = 4'b0100;
        repeat (DT) next_tick();
        step_clk();
        next_tick();
        n_checks++;
        if ({key_valid, key_value} !== {1'b1, 4'hB})
            $display("FAIL pre-reset-press: got %b expected %b", {key_valid, key_value}, {1'b1, 4'hB});
        else n_pass++;
        #3;
        reset_p = 1'b1;
        #1;
        n_checks++;
        if ({key_valid, col, key_value} !== {1'b0, 4'b0001, 4'h0})
            $display("FAIL reset-mid: got %b expected %b", {key_valid, col, key_value}, {1'b0, 4'b0001, 4'h0});
        else n_pass++;
        row = 4'd0;
        @(posedge clk);
        #1;
        reset_p   = 1'b0;
        phase     = 0;
        mcol      = 0;
        last_code = 4'd0;
        next_tick();
        mcol = 1;
        n_checks++;
        if ({key_valid, col} !== {1'b0, 4'b0010})
            $display("FAIL reset-restart: got %b expected %b", {key_valid, col}, {1'b0, 4'b0010});
        else n_pass++;
    endtask

    task automatic test_long_hold;
        run_press(1, 4'b1000, 20, 0);
    endtask

    task automatic test_random;
        int         c;
        logic [3:0] r;
        for (int it = 0; it < 8; it++) begin
            c = int'($urandom_range(0, 3));
            r = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 2) == 0) begin
                test_bounce(c, r, int'($urandom_range(1, DT - 1)));
            end else begin
                run_press(c, r, int'($urandom_range(0, 7)), int'($urandom_range(0, DT - 1)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_press_basic();
        test_bounce(0, 4'b0001, 1);
        test_multirow_glitch();
        test_reset_mid();
        test_long_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
